// File: rtl/mygo_pack_pkg.sv
// Shared types and helpers for the mygo byte packer: lane index type,
// packer state encoding and the lane keep-mask builder.
package mygo_pack_pkg;

    localparam int unsigned MAX_LANES  = 16;
    localparam int unsigned LANE_IDX_W = $clog2(MAX_LANES);

    // Sized for the widest legal configuration so one type serves every LANES value.
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_e;

    function automatic logic [MAX_LANES-1:0] keep_mask(input logic [LANE_IDX_W:0] n);
        logic [MAX_LANES:0] m;
        m = ((MAX_LANES+1)'(1'b1) << n) - (MAX_LANES+1)'(1'b1);
        return MAX_LANES'(m);
    endfunction

endpackage

// File: rtl/mygo_pack_outreg.sv
// One-entry output holding register with valid/ready; reports whether it can
// take a new word this cycle (empty, or being drained right now).
module mygo_pack_outreg
    import mygo_pack_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_valid,
    output logic              space
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;

    // Next-state for the holding register: load wins over drain, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            keep_d  = load_keep;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign space     = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;

endmodule

// File: rtl/mygo_byte_packer.sv
// Packs LANES narrow tokens little-endian into one wide word with a keep mask.
// Define MYGO_PACKER_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module mygo_byte_packer
    import mygo_pack_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned LANES    = 4
`ifdef MYGO_PACKER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT  = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [IN_WIDTH*LANES-1:0] out_data,
    output logic [LANES-1:0]          out_keep,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH * LANES;

    pack_state_e          state_q, state_d;
    lane_idx_t            lane_q, lane_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;

    logic                 space_s;
    logic                 accept_s;
    logic                 complete_s;
    logic                 load_s;
    logic [OUT_WIDTH-1:0] word_s;
    logic [OUT_WIDTH-1:0] load_data_s;
    logic [LANES-1:0]     load_keep_s;

`ifdef MYGO_PACKER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [IDLE_W-1:0] idle_inc_s;
    logic              flush_s;

    // Idle counter saturates at TIMEOUT so a blocked flush fires once space opens.
    always_comb begin
        if (idle_q == IDLE_W'(TIMEOUT)) begin
            idle_inc_s = idle_q;
        end else begin
            idle_inc_s = idle_q + IDLE_W'(1);
        end
        flush_s = (state_q == FILL) && !accept_s && (idle_inc_s == IDLE_W'(TIMEOUT)) && space_s;
        if (accept_s || (state_q != FILL) || flush_s) begin
            idle_d = '0;
        end else begin
            idle_d = idle_inc_s;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // Accept/complete decode, lane insertion and packer next-state.
    always_comb begin
        accept_s = in_valid && space_s;
        word_s   = acc_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == lane_idx_t'(k)) begin
                word_s[k*IN_WIDTH +: IN_WIDTH] = in_data;
            end else begin
                word_s[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
            end
        end
        complete_s = accept_s &&
                     (in_last || ((state_q == FILL) && (lane_q == lane_idx_t'(LANES - 1))));

        state_d     = state_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        load_s      = 1'b0;
        load_data_s = word_s;
        load_keep_s = LANES'(keep_mask({1'b0, lane_q} + (LANE_IDX_W+1)'(1)));

        if (complete_s) begin
            load_s  = 1'b1;
            acc_d   = '0;
            lane_d  = '0;
            state_d = IDLE;
        end else if (accept_s) begin
            acc_d   = word_s;
            lane_d  = lane_q + lane_idx_t'(1);
            state_d = FILL;
        end else begin
`ifdef MYGO_PACKER_TIMEOUT_EN
            // Flushed word carries only the lanes already filled.
            if (flush_s) begin
                load_s      = 1'b1;
                load_data_s = acc_q;
                load_keep_s = LANES'(keep_mask({1'b0, lane_q}));
                acc_d       = '0;
                lane_d      = '0;
                state_d     = IDLE;
            end else begin
                state_d = state_q;
            end
`else
            state_d = state_q;
`endif
        end
    end

    // Packer state, lane counter and accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            acc_q   <= acc_d;
        end
    end

    mygo_pack_outreg #(
        .DATA_W (OUT_WIDTH),
        .KEEP_W (LANES)
    ) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (load_data_s),
        .load_keep (load_keep_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .space     (space_s)
    );

    assign in_ready = space_s;

endmodule

// File: tb/tb_mygo_byte_packer.sv
// Scoreboard bench for mygo_byte_packer: directed token streams push expected
// words; a monitor pops and compares on every emitted word.
module tb_mygo_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    word_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    mygo_byte_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        word_t w;
        w.d = d;
        w.k = k;
        exp_q.push_back(w);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one token and hold it until the packer takes it (bounded).
    task automatic send(input logic [7:0] d, input logic l);
        logic ok;
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: token 0x%0h not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: scoreboard pop on every emit, stability check while held.
    initial begin
        word_t       e;
        logic        hold_prev;
        logic [31:0] hold_d;
        logic [3:0]  hold_k;
        hold_prev = 1'b0;
        hold_d    = '0;
        hold_k    = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev && out_valid) begin
                    check("hold_data", out_data, hold_d);
                    check("hold_keep", {28'd0, out_keep}, {28'd0, hold_k});
                end
                hold_prev = out_valid && !out_ready;
                hold_d    = out_data;
                hold_k    = out_keep;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_word: got 0x%0h keep %b, expected no word", out_data, out_keep);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", out_data, e.d);
                        check("word_keep", {28'd0, out_keep}, {28'd0, e.k});
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        rst       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_keep", {28'd0, out_keep}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycles(2);

        // Full word, visible one cycle after the fourth accept.
        expect_word(32'h44332211, 4'b1111);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("t1_not_early", {31'd0, out_valid}, 32'd0);
        send(8'h44, 1'b0);
        check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        check("t1_latency_data", out_data, 32'h44332211);
        cycles(3);

        // Early close, then a single-token word restarting at lane 0.
        expect_word(32'h0000BBAA, 4'b0011);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        expect_word(32'h0000005A, 4'b0001);
        send(8'h5A, 1'b1);
        check("t4_single_keep", {28'd0, out_keep}, 32'd1);
        cycles(3);

        // Back-pressure: first word held, second stream stalls until release.
        expect_word(32'h04030201, 4'b1111);
        expect_word(32'h08070605, 4'b1111);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        out_ready = 1'b0;
        #1;
        check("t3_in_ready_drop", {31'd0, in_ready}, 32'd0);
        fork
            begin
                send(8'h05, 1'b0);
                send(8'h06, 1'b0);
                send(8'h07, 1'b0);
                send(8'h08, 1'b0);
            end
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("t3_in_ready_held", {31'd0, in_ready}, 32'd0);
                    check("t3_held_data", out_data, 32'h04030201);
                end
                out_ready = 1'b1;
            end
        join
        cycles(3);

        // Reset mid-word discards the partial word.
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        rst = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_data", out_data, 32'd0);
        check("t5_rst_keep", {28'd0, out_keep}, 32'd0);
        cycles(2);
        rst = 1'b1;
        cycles(4);
        check("t5_quiet_after_rst", {31'd0, out_valid}, 32'd0);
        expect_word(32'hC4C3C2C1, 4'b1111);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        cycles(3);

`ifdef MYGO_PACKER_TIMEOUT_EN
        // Partial word flushed exactly 16 idle cycles after its last accept.
        expect_word(32'h00002010, 4'b0011);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        check("t6_timeout_cycles", cyc, 32'd16);
        check("t6_timeout_keep", {28'd0, out_keep}, 32'd3);
`else
        // Without the timeout a partial word waits indefinitely.
        cyc = 0;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) cyc = i;
        end
        check("t6_no_flush", cyc, 32'd0);
`endif
        cycles(3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycles(1);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mygo_byte_packer.md
Name: mygo_byte_packer

Overview:
- Downstream consumer of an 8-bit channel FIFO (i8 flavour) in generated pipelines.
- Pops narrow tokens, packs LANES consecutive tokens little-endian into one wide word, pushes the word toward a 32-bit channel FIFO.
- A sideband last flag closes a partial word early.
- Both sides use valid/ready handshakes identical to the FIFO ports.

Parameters:
- IN_WIDTH, 8, width of one input token.
- LANES, 4, tokens per output word; legal range 2..16.
- OUT_WIDTH, IN_WIDTH*LANES, output word width; derived, never overridden.
- TIMEOUT, 16, idle cycles before a partial word is force-flushed (only with the optional feature).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset; one clock domain only.
- in_data  input  IN_WIDTH  token from the FIFO out_data.
- in_valid  input  1  FIFO out_valid.
- in_last  input  1  sideband; token closes the current word.
- in_ready  output  1  drives FIFO out_ready.
- out_data  output  OUT_WIDTH  packed word.
- out_keep  output  LANES  bit i set when lane i holds a real token.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (rst low, async assert, sync release): out_valid=0, out_data=0, out_keep=0, lane counter=0, accumulator=0, state IDLE, idle counter=0.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is registered-state-only; there is no combinational path from in_valid/in_data/in_last to in_ready.
- Token k of a word lands at bits [k*IN_WIDTH +: IN_WIDTH]; the first token is at the LSBs.
- States:
  - IDLE: lane=0. On accept, go to FILL, or go straight to completion if in_last=1.
  - FILL: 0<lane<LANES. A word completes on the accept with lane==LANES-1 or with in_last=1.
- On the completing accept, the output register loads {accumulator with the new token} in the same edge. Unfilled lanes are 0. out_keep = (1<<(lane+1))-1. out_valid=1. Lane returns to 0 and state to IDLE.
- Latency: the word is visible 1 cycle after its completing token is accepted.
- Throughput: 1 token/cycle while out_ready=1.
- Simultaneous emit and completing accept in the same cycle: the new word replaces the old one, out_valid stays 1, and no bubble occurs.
- Output held (out_valid=1, out_ready=0): in_ready=0. The accumulator and lane counter are frozen, and out_data/out_keep are stable.
- in_last on a token that also fills lane LANES-1: one full word; out_keep all ones.
- in_last with lane=0: single-token word, out_keep=1.
- Lane wrap: the counter is modulo LANES and never exceeds LANES-1.
- Reset mid-word or mid-hold: the partial word and held word are discarded; no output after reset until new tokens arrive.

Optional Feature:
- Macro MYGO_PACKER_TIMEOUT_EN.
- Defined: while in FILL with no accept, an idle counter increments each cycle. When it reaches TIMEOUT and the output register is free (out_valid=0, or emit this cycle), the partial word is flushed exactly as if in_last had arrived on the last real token (keep = filled lanes only). Any accept clears the counter. A flush and an accept never coincide; the accept wins and the counter restarts.
- Undefined: no idle counter and no TIMEOUT logic is synthesised. Partial words wait indefinitely for in_last or a full lane count.

Decomposition:
- Package mygo_pack_pkg:
  - lane index typedef (clog2 LANES);
  - keep-mask helper function computing (1<<n)-1;
  - state enum {IDLE, FILL}.
- Sub-module mygo_pack_outreg: one-entry output holding register with valid/ready, load and stall. It owns out_data/out_keep/out_valid and produces the space signal used for in_ready.

Test Plan:
- Stream 0x11,0x22,0x33,0x44 with out_ready=1 -> one word 0x44332211, keep 4'b1111, one cycle after the 4th accept.
- 0xAA then 0xBB with in_last=1 -> word 0x0000BBAA, keep 4'b0011. The next tokens start at lane 0.
- 8 back-to-back tokens 0x01..0x08, out_ready held 0 after the first word -> in_ready drops the cycle after the first word. Word 0x04030201 stays stable. On release, 0x08070605 follows with no lost or duplicated token.
- Single token 0x5A with in_last at lane 0 -> word 0x0000005A, keep 4'b0001.
- rst pulled low after 2 tokens, then 0xC1..0xC4 -> only 0xC4C3C2C1 is emitted; outputs are 0 during reset.
- With MYGO_PACKER_TIMEOUT_EN, TIMEOUT=16: tokens 0x10,0x20, then idle -> word 0x00002010, keep 4'b0011, exactly 16 idle cycles after the 2nd accept. Without the macro, nothing is emitted.
